// File: rtl/video_border_overlay.sv
// Purpose  : AXI4-Stream video stage that tracks pixel position from tuser/tlast, paints a
//            programmable-thickness solid border over the frame and flags SOF/EOL framing errors.
// Latency  : 1 cycle (beat accepted at edge N is on m_axis_* in cycle N+1); err_* 1 cycle after accept.
// Backpress: output register + one skid register; s_axis_tready = !skid_valid (registered), so the
//            upstream may push at most one beat after m_axis_tready drops; full rate when unstalled.
//
// Ports:
//   clk, rst                     - rising-edge clock, asynchronous active-high reset
//   en, border_w, border_color   - overlay controls, latched into frame registers on each SOF beat
//   s_axis_t{data,valid,ready,user,last} - input pixel stream (tuser = pixel (0,0), tlast = end of line)
//   m_axis_t{data,valid,ready,user,last} - output pixel stream, tuser/tlast aligned with their pixel
//   err_sof, err_eol             - one-cycle framing error pulses
module video_border_overlay #(
    parameter int DATA_WIDTH    = 24,
    parameter int SCREEN_WIDTH  = 1920,
    parameter int SCREEN_HEIGHT = 1080
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            border_w,
    input  logic [DATA_WIDTH-1:0] border_color,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  err_sof,
    output logic                  err_eol
);

    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_HEIGHT - 1);
    localparam logic [12:0]   W13   = 13'(SCREEN_WIDTH);
    localparam logic [12:0]   H13   = 13'(SCREEN_HEIGHT);

    typedef struct packed {
        logic                  user;
        logic                  last;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    // Position of the next expected input beat and framing state
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         y_cnt;
    logic                  synced;

    // Overlay controls captured at SOF so mid-frame changes wait for the next frame
    logic                  frame_en;
    logic [7:0]            frame_bw;
    logic [DATA_WIDTH-1:0] frame_color;

    // Output register and skid register
    beat_t                 out_beat;
    beat_t                 skid_beat;
    logic                  out_vld;
    logic                  skid_vld;
    logic                  skid_vld_nxt;
    logic                  in_rdy;
    logic                  out_free;

    logic                  err_sof_r;
    logic                  err_eol_r;

    // Per-beat combinational decode
    logic                  in_fire;
    logic [XW-1:0]         beat_x;
    logic [YW-1:0]         beat_y;
    logic [XW-1:0]         x_nxt;
    logic [YW-1:0]         y_nxt;
    logic                  sync_eff;
    logic                  en_eff;
    logic [7:0]            bw_eff;
    logic [DATA_WIDTH-1:0] color_eff;
    logic                  at_x_max;
    logic                  line_end;
    logic                  sof_err;
    logic                  eol_err;
    logic [12:0]           bx13;
    logic [12:0]           by13;
    logic [12:0]           bw13;
    logic                  in_border;
    beat_t                 in_beat;

    always_comb begin
        in_fire   = s_axis_tvalid && in_rdy;

        // A tuser beat is (0,0) by definition, whatever the counters expected
        beat_x    = s_axis_tuser ? '0 : x_cnt;
        beat_y    = s_axis_tuser ? '0 : y_cnt;
        sync_eff  = synced || s_axis_tuser;

        // The SOF beat itself already uses the controls being sampled on it
        en_eff    = s_axis_tuser ? en           : frame_en;
        bw_eff    = s_axis_tuser ? border_w     : frame_bw;
        color_eff = s_axis_tuser ? border_color : frame_color;

        at_x_max  = (beat_x == X_MAX);
        line_end  = s_axis_tlast || at_x_max;

        // SOF errors compare against the expected position, so only meaningful once synced
        sof_err   = synced && (s_axis_tuser ? ((x_cnt != '0) || (y_cnt != '0))
                                            : ((x_cnt == '0) && (y_cnt == '0)));
        eol_err   = sync_eff && (s_axis_tlast != at_x_max);

        // 13-bit unsigned compares: an oversized border wraps SCREEN-bw to a large value,
        // but the x<bw / y<bw terms then already cover the whole frame
        bx13      = 13'(beat_x);
        by13      = 13'(beat_y);
        bw13      = 13'(bw_eff);
        in_border = (bx13 < bw13) || (bx13 >= (W13 - bw13)) ||
                    (by13 < bw13) || (by13 >= (H13 - bw13));

        in_beat.user = s_axis_tuser;
        in_beat.last = s_axis_tlast;
        in_beat.dat  = (sync_eff && en_eff && in_border) ? color_eff : s_axis_tdata;

        if (line_end) begin
            x_nxt = '0;
            y_nxt = (beat_y == Y_MAX) ? '0 : beat_y + YW'(1);
        end else begin
            x_nxt = beat_x + XW'(1);
            y_nxt = beat_y;
        end
    end

    // Position tracking, SOF capture and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            synced      <= 1'b0;
            frame_en    <= 1'b0;
            frame_bw    <= '0;
            frame_color <= '0;
            err_sof_r   <= 1'b0;
            err_eol_r   <= 1'b0;
        end else begin
            err_sof_r <= in_fire && sof_err;
            err_eol_r <= in_fire && eol_err;
            if (in_fire) begin
                x_cnt <= x_nxt;
                y_cnt <= y_nxt;
                if (s_axis_tuser) begin
                    synced      <= 1'b1;
                    frame_en    <= en;
                    frame_bw    <= border_w;
                    frame_color <= border_color;
                end
            end
        end
    end

    // Output register can take a new beat when empty or being consumed this cycle
    always_comb begin
        out_free     = !out_vld || m_axis_tready;
        skid_vld_nxt = out_free ? 1'b0 : (skid_vld || in_fire);
    end

    // in_rdy mirrors !skid_vld, so a beat never arrives while the skid register is occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat  <= '0;
            out_vld   <= 1'b0;
            skid_beat <= '0;
            skid_vld  <= 1'b0;
            in_rdy    <= 1'b0;
        end else begin
            skid_vld <= skid_vld_nxt;
            in_rdy   <= !skid_vld_nxt;
            if (out_free) begin
                if (skid_vld) begin
                    out_beat <= skid_beat;
                    out_vld  <= 1'b1;
                end else begin
                    out_vld <= in_fire;
                    if (in_fire) begin
                        out_beat <= in_beat;
                    end
                end
            end else if (in_fire) begin
                skid_beat <= in_beat;
            end
        end
    end

    assign s_axis_tready = in_rdy;
    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_beat.dat;
    assign m_axis_tuser  = out_beat.user;
    assign m_axis_tlast  = out_beat.last;
    assign err_sof       = err_sof_r;
    assign err_eol       = err_eol_r;

endmodule

// File: tb/tb_video_border_overlay.sv
module tb_video_border_overlay;

    localparam int DW = 24;
    localparam int W  = 8;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    border_w;
    logic [DW-1:0] border_color;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          err_sof;
    logic          err_eol;

    always #5 clk = ~clk;

    video_border_overlay #(
        .DATA_WIDTH   (DW),
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .border_w     (border_w),
        .border_color (border_color),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .err_sof      (err_sof),
        .err_eol      (err_eol)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } exp_t;

    int       vectors     = 0;
    int       miscompares = 0;

    // Reference model state: pixels in flight, expected next position, frame controls
    exp_t     q[$];
    int       mx, my, m_bw;
    bit       msynced, m_en;
    logic [DW-1:0] m_col;
    bit       exp_sof, exp_eol;
    bit       chk_rdy, rnd_rdy, rnd_par, ramp;
    int       dseq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_m_tvalid"}, 32'(m_axis_tvalid), 0);
        chk({p, "_m_tdata"},  32'(m_axis_tdata),  0);
        chk({p, "_m_tuser"},  32'(m_axis_tuser),  0);
        chk({p, "_m_tlast"},  32'(m_axis_tlast),  0);
        chk({p, "_err_sof"},  32'(err_sof),       0);
        chk({p, "_err_eol"},  32'(err_eol),       0);
        chk({p, "_s_tready"}, 32'(s_axis_tready), 0);
    endtask

    task automatic model_reset();
        q.delete();
        mx = 0; my = 0; msynced = 0; m_en = 0; m_bw = 0; m_col = '0;
        exp_sof = 0; exp_eol = 0;
    endtask

    // Frame semantics straight from the rules: where the pixel sits, whether it is in the border
    task automatic model_beat();
        int   bx, by;
        bit   bord;
        exp_t e;
        bx = s_axis_tuser ? 0 : mx;
        by = s_axis_tuser ? 0 : my;
        exp_sof = msynced && (s_axis_tuser ? (mx != 0 || my != 0) : (mx == 0 && my == 0));
        exp_eol = (msynced || s_axis_tuser) && (s_axis_tlast != (bx == W - 1));
        if (s_axis_tuser) begin
            msynced = 1; m_en = en; m_bw = int'(border_w); m_col = border_color;
        end
        bord = (bx < m_bw) || (bx >= W - m_bw) || (by < m_bw) || (by >= H - m_bw);
        e.d = (msynced && m_en && bord) ? m_col : s_axis_tdata;
        e.u = s_axis_tuser;
        e.l = s_axis_tlast;
        q.push_back(e);
        if (s_axis_tlast || bx == W - 1) begin
            mx = 0; my = (by + 1) % H;
        end else begin
            mx = bx + 1; my = by;
        end
    endtask

    // One clock: sample at negedge, update model, check error pulses #1 after posedge
    task automatic cycle(output bit acc);
        exp_t e;
        @(negedge clk);
        if (chk_rdy) chk("s_tready", 32'(s_axis_tready), 32'(q.size() < 2));
        chk("m_tvalid", 32'(m_axis_tvalid), 32'(q.size() != 0));
        acc = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
            e = q.pop_front();
            chk("m_tdata", 32'(m_axis_tdata), 32'(e.d));
            chk("m_tuser", 32'(m_axis_tuser), 32'(e.u));
            chk("m_tlast", 32'(m_axis_tlast), 32'(e.l));
        end
        if (acc) model_beat();
        else begin exp_sof = 0; exp_eol = 0; end
        @(posedge clk);
        #1;
        chk("err_sof", 32'(err_sof), 32'(exp_sof));
        chk("err_eol", 32'(err_eol), 32'(exp_eol));
        if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input bit u, input bit l);
        bit acc;
        int r;
        s_axis_tdata  = ramp ? DW'(dseq) : DW'($urandom);
        dseq++;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        if (rnd_par) begin
            r            = $urandom_range(0, 4);
            en           = 1'($urandom_range(0, 1));
            border_w     = (r == 4) ? 8'd255 : 8'(r);
            border_color = DW'($urandom);
        end
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) cycle(acc);
        chk("accept", 32'(acc), 1);
    endtask

    task automatic drain();
        bit acc;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < 100 && q.size() != 0; i++) cycle(acc);
        chk("drain", 32'(q.size()), 0);
    endtask

    task automatic send_frame(input bit with_user);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                send_beat(with_user && x == 0 && y == 0, x == W - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        rst = 1'b1; en = 1'b0; border_w = '0; border_color = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        chk_rdy = 0; rnd_rdy = 0; rnd_par = 0; ramp = 1; dseq = 0;
        model_reset();

        // Reset state, then tready rises on the first edge after release
        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(acc);
        chk("tready_after_rst", 32'(s_axis_tready), 1);
        chk_rdy = 1;

        // One frame, 1-pixel red border over ramp data
        en = 1'b1; border_w = 8'd1; border_color = 24'hFF0000;
        send_frame(1);
        drain();

        // Random output stalls and random controls (only SOF values matter) over 3 frames
        ramp = 0; rnd_rdy = 1; rnd_par = 1;
        repeat (3) send_frame(1);
        drain();
        rnd_rdy = 0; rnd_par = 0; m_axis_tready = 1'b1;

        // Early tlast at x=5 of line 1; next beat becomes (0,2)
        en = 1'b1; border_w = 8'd1; border_color = 24'h00FF00;
        for (int x = 0; x < W; x++) send_beat(x == 0, x == W - 1);
        for (int x = 0; x < 6; x++) send_beat(0, x == 5);
        for (int y = 2; y < H; y++)
            for (int x = 0; x < W; x++) send_beat(0, x == W - 1);
        send_frame(1);
        drain();

        // Missing tuser at (0,0), then a tuser at (3,1) resyncs to (0,0)
        for (int x = 0; x < W; x++) send_beat(0, x == W - 1);
        for (int x = 0; x < 3; x++) send_beat(0, 0);
        for (int x = 0; x < W; x++) send_beat(x == 0, x == W - 1);
        for (int y = 1; y < H; y++)
            for (int x = 0; x < W; x++) send_beat(0, x == W - 1);
        drain();

        // border_w 1 -> 2 mid-frame takes effect next frame; then en=0 frame passes through
        border_w = 8'd1; border_color = 24'h0000FF;
        for (int i = 0; i < W * H; i++) begin
            if (i == 10) border_w = 8'd2;
            send_beat(i == 0, (i % W) == W - 1);
        end
        send_frame(1);
        en = 1'b0;
        send_frame(1);
        en = 1'b1;
        drain();

        // Reset with the output and skid registers both full
        m_axis_tready = 1'b0;
        send_beat(1, 0);
        send_beat(0, 0);
        chk("tready_skid_full", 32'(s_axis_tready), 0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        chk_rdy = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        cycle(acc);
        chk("tready_after_midrst", 32'(s_axis_tready), 1);
        chk_rdy = 1;

        // Unsynced: full-fill border requested but data must pass until the next tuser
        border_w = 8'd3; border_color = 24'h123456;
        for (int x = 0; x < W; x++) send_beat(0, x == W - 1);
        send_frame(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_border_overlay.md
# video_border_overlay

AXI4-Stream video stage that sits directly downstream of the BRAM image generator and upstream of the video output path. It tracks pixel position from tuser/tlast, replaces pixels in a programmable-thickness border with a solid color, and flags framing errors. A two-entry skid buffer gives full throughput with a registered tready.

## Interface
Parameters:
- DATA_WIDTH, 24, pixel width in bits (RGB 8:8:8)
- SCREEN_WIDTH, 1920, active pixels per line
- SCREEN_HEIGHT, 1080, active lines per frame

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  border overlay enable; sampled on each SOF beat
- border_w  in  8  border thickness in pixels; sampled on each SOF beat
- border_color  in  DATA_WIDTH  replacement pixel value; sampled on each SOF beat
- s_axis_tdata  in  DATA_WIDTH  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tuser  in  1  start of frame, pixel (0,0)
- s_axis_tlast  in  1  end of line
- m_axis_tdata  out  DATA_WIDTH  output pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tuser  out  1  start of frame, passed through
- m_axis_tlast  out  1  end of line, passed through
- err_sof  out  1  one-cycle pulse: tuser misplaced or missing
- err_eol  out  1  one-cycle pulse: tlast early or late

## Operation
- Beat accepted when s_axis_tvalid && s_axis_tready.
- Position counters x (0..SCREEN_WIDTH-1) and y (0..SCREEN_HEIGHT-1) give the expected position of the next input beat. Widths are clog2 of the parameter.
- tuser on an accepted beat: that beat is (0,0). The synced flag sets. en, border_w and border_color are latched into frame registers.
- After each beat, the line ends if tlast==1 or x==SCREEN_WIDTH-1. At line end, x goes to 0 and y increments, wrapping to 0 after SCREEN_HEIGHT-1. Otherwise x increments.
- err_eol fires when tlast==1 with x!=SCREEN_WIDTH-1 (early), or when tlast==0 with x==SCREEN_WIDTH-1 (late).
- err_sof fires when synced and either tuser==1 at expected position other than (0,0), or tuser==0 at expected (0,0).
- Unsynced (after reset, before first tuser): data passes unmodified and no errors are flagged.
- Border test uses the position of the beat itself (tuser forces 0,0). A pixel is in the border if x<bw, or x>=SCREEN_WIDTH-bw, or y<bw, or y>=SCREEN_HEIGHT-bw, using 13-bit unsigned compares.
  - bw=0 gives no border.
  - bw>=min(W,H)/2 gives the whole frame filled.
- Border pixels, when the latched en is 1 and synced, output the latched border_color. All other pixels pass s_axis_tdata.
- tuser and tlast pass through unchanged and aligned with their pixel.
- Skid buffer: an output register plus one skid register.
  - s_axis_tready = !skid_valid, registered.
  - When the output is stalled and the output register is full, an accepted beat goes to the skid register.
  - The skid register drains into the output register when m_axis_tready is high.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, err_sof=0, err_eol=0, s_axis_tready=0. Counters 0, synced=0, skid empty, frame registers 0.
- s_axis_tready rises on the first clk edge after rst deasserts.
- Latency: input beat accepted at edge N appears on m_axis_* after edge N (valid in cycle N+1).
- err_* pulses are asserted in the cycle after the offending beat is accepted, for exactly 1 cycle.
- Throughput: 1 beat/cycle while m_axis_tready=1.
- After m_axis_tready drops, at most 1 further beat is accepted, into the skid register, and tready is low from the next cycle.
- m_axis_* is held stable while m_axis_tvalid && !m_axis_tready. There are no bubbles or reordering.
- Reset mid-frame: all state clears immediately. Any buffered beats are dropped, and the block is unsynced until the next tuser.
- Parameter changes in mid-frame have no effect until the next SOF.

## Test plan
Use W=8 and H=4 for all tests.
- Reset then one frame, en=1, border_w=1, color=0xFF0000, ramp input data:
  - rows 0 and 3, and columns 0 and 7, are 0xFF0000
  - all other pixels equal the input
  - tuser is on the first output beat, and tlast on every 8th
- Random m_axis_tready (50%) with continuous input over 3 frames:
  - output sequence is identical to the unstalled run
  - no beat is lost or duplicated
  - at most 1 beat is accepted after tready drops
- tlast at x=5 in line 1:
  - err_eol pulses once, 1 cycle later
  - next beat is treated as (0,2)
  - border columns follow the new x
- Second frame missing tuser at (0,0): err_sof pulses once. Then a tuser at (3,1) gives another err_sof, and counters resync to (0,0) on that beat.
- border_w changed from 1 to 2 mid-frame: current frame keeps 1-pixel border, the next frame has 2-pixel border. With en=0 at SOF, the output equals the input for the whole frame.
- rst asserted with a beat in the skid register:
  - all outputs are 0 immediately
  - s_axis_tready=1 one cycle after release
  - no overlay until the next tuser
